// File: rtl/rtc_bus_sequencer.sv
// Sequences RTC generator frames (6-register read sweep or single host write) and owns the
// multiplexed address/data bus. Optional BCD validation of captured bytes: RTC_BCD_CHECK_EN.
module rtc_bus_sequencer #(
   parameter logic [7:0] BASE_ADDR      = 8'h21,
   parameter int         TIMEOUT_CYCLES = 200,
   parameter int         TO_W           = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sweep_req,
   input  logic       wr_req,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       indicador_maquina,
   output logic       gen_start,
   input  logic       cs_n,
   input  logic       ad_n,
   input  logic       rd_n,
   input  logic       wr_n,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic [7:0] ad_in,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic [7:0] hour,
   output logic [7:0] day,
   output logic [7:0] month,
   output logic [7:0] year,
   output logic       sweep_done,
`ifdef RTC_BCD_CHECK_EN
   output logic       bcd_err,
`endif
   output logic       timeout_err
);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ADDR, S_DATA, S_FINISH} state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   state_t          state_q, state_d;
   logic            op_wr_q, op_wr_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [2:0]      idx_q, idx_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            cs_prev_q, cs_prev_d;
   logic            ad_prev_q, ad_prev_d;
   logic            rd_prev_q, rd_prev_d;
   logic            wr_prev_q, wr_prev_d;
   logic            busy_q, busy_d;
   logic            gen_start_q, gen_start_d;
   logic            ind_q, ind_d;
   logic [7:0]      ad_out_q, ad_out_d;
   logic [7:0]      time_q [6];
   logic [7:0]      time_d [6];
   logic            sweep_done_q, sweep_done_d;
   logic            timeout_err_q, timeout_err_d;
`ifdef RTC_BCD_CHECK_EN
   logic            bcd_err_q, bcd_err_d;
`endif

   logic       ad_rise, rd_rise, wr_rise, timed_out, in_wait;
   logic [7:0] target_addr;

   assign ad_rise     = ~ad_prev_q & ad_n;
   assign rd_rise     = ~rd_prev_q & rd_n;
   assign wr_rise     = ~wr_prev_q & wr_n;
   assign in_wait     = (state_q == S_ADDR) | (state_q == S_DATA) | (state_q == S_FINISH);
   assign timed_out   = in_wait & (to_cnt_q == TO_LIMIT);
   assign target_addr = op_wr_q ? addr_q : (BASE_ADDR + {5'd0, idx_q});

   // Bus is driven only while the generator strobes ask for it; released on timeout and reset.
   assign ad_oe = ~timed_out & ~cs_n &
                  (((state_q == S_ADDR) & ~ad_n) |
                   ((state_q == S_DATA) & op_wr_q & ~wr_n));

   always_comb begin
      state_d       = state_q;
      op_wr_d       = op_wr_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      idx_d         = idx_q;
      to_cnt_d      = to_cnt_q;
      cs_prev_d     = cs_n;
      ad_prev_d     = ad_n;
      rd_prev_d     = rd_n;
      wr_prev_d     = wr_n;
      ad_out_d      = ad_out_q;
      time_d        = time_q;
      sweep_done_d  = 1'b0;
      timeout_err_d = timeout_err_q;
`ifdef RTC_BCD_CHECK_EN
      bcd_err_d     = bcd_err_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (wr_req || sweep_req) begin
               op_wr_d       = wr_req;
               idx_d         = 3'd0;
               timeout_err_d = 1'b0;
`ifdef RTC_BCD_CHECK_EN
               bcd_err_d     = 1'b0;
`endif
               state_d       = S_LAUNCH;
               if (wr_req) begin
                  addr_d  = wr_addr;
                  wdata_d = wr_data;
               end
            end
         end
         S_LAUNCH: begin
            to_cnt_d = '0;
            ad_out_d = target_addr;
            state_d  = S_ADDR;
         end
         S_ADDR: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (timed_out) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else if (ad_rise) begin
               state_d = S_DATA;
               if (op_wr_q) ad_out_d = wdata_q;
            end
         end
         S_DATA: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (timed_out) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else if (op_wr_q) begin
               if (wr_rise) state_d = S_FINISH;
            end else if (rd_rise && !cs_n) begin
               state_d = S_FINISH;
               for (int i = 0; i < 6; i++) begin
                  if (idx_q == 3'(i)) begin
`ifdef RTC_BCD_CHECK_EN
                     if (ad_in[7:4] > 4'd9 || ad_in[3:0] > 4'd9) bcd_err_d = 1'b1;
                     else                                        time_d[i] = ad_in;
`else
                     time_d[i] = ad_in;
`endif
                  end
               end
            end
         end
         S_FINISH: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (timed_out) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end else if (cs_n) begin
               if (!op_wr_q && idx_q != 3'd5) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_LAUNCH;
               end else begin
                  sweep_done_d = ~op_wr_q;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d      = (state_d != S_IDLE);
      gen_start_d = (state_d == S_LAUNCH);
      ind_d       = (state_d == S_LAUNCH) ? ~op_wr_d : ind_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         op_wr_q       <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         idx_q         <= '0;
         to_cnt_q      <= '0;
         cs_prev_q     <= 1'b1;
         ad_prev_q     <= 1'b1;
         rd_prev_q     <= 1'b1;
         wr_prev_q     <= 1'b1;
         busy_q        <= 1'b0;
         gen_start_q   <= 1'b0;
         ind_q         <= 1'b1;
         ad_out_q      <= '0;
         for (int i = 0; i < 6; i++) time_q[i] <= '0;
         sweep_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
         bcd_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         op_wr_q       <= op_wr_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         idx_q         <= idx_d;
         to_cnt_q      <= to_cnt_d;
         cs_prev_q     <= cs_prev_d;
         ad_prev_q     <= ad_prev_d;
         rd_prev_q     <= rd_prev_d;
         wr_prev_q     <= wr_prev_d;
         busy_q        <= busy_d;
         gen_start_q   <= gen_start_d;
         ind_q         <= ind_d;
         ad_out_q      <= ad_out_d;
         time_q        <= time_d;
         sweep_done_q  <= sweep_done_d;
         timeout_err_q <= timeout_err_d;
`ifdef RTC_BCD_CHECK_EN
         bcd_err_q     <= bcd_err_d;
`endif
      end
   end

   assign busy              = busy_q;
   assign gen_start         = gen_start_q;
   assign indicador_maquina = ind_q;
   assign ad_out            = ad_out_q;
   assign sec               = time_q[0];
   assign min               = time_q[1];
   assign hour              = time_q[2];
   assign day               = time_q[3];
   assign month             = time_q[4];
   assign year              = time_q[5];
   assign sweep_done        = sweep_done_q;
   assign timeout_err       = timeout_err_q;
`ifdef RTC_BCD_CHECK_EN
   assign bcd_err           = bcd_err_q;
`endif

   // cs_n prior sample is tracked for completeness of the edge-detect set; FINISH uses the live level.
   logic unused_ok;
   assign unused_ok = cs_prev_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: plays the RTC generator and checks against a register-level model.
// Build with RTC_BCD_CHECK_EN to exercise bcd_err.
module tb_rtc_bus_sequencer;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sweep_req = 1'b0, wr_req = 1'b0;
   logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
   logic       cs_n = 1'b1, ad_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
   logic [7:0] ad_in = 8'h00;
   logic       busy, indicador_maquina, gen_start, ad_oe, sweep_done, timeout_err;
   logic [7:0] ad_out, sec, min, hour, day, month, year;
`ifdef RTC_BCD_CHECK_EN
   logic       bcd_err;
`endif

   rtc_bus_sequencer dut (
      .clk(clk), .reset(reset), .sweep_req(sweep_req), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .indicador_maquina(indicador_maquina), .gen_start(gen_start),
      .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
      .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
      .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
      .sweep_done(sweep_done),
`ifdef RTC_BCD_CHECK_EN
      .bcd_err(bcd_err),
`endif
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int gs_cnt = 0, sd_cnt = 0;
   logic [7:0] exp_t [6];
   logic [7:0] dut_t [6];
   bit         exp_bcd;

   always_comb dut_t = '{sec, min, hour, day, month, year};

   always @(negedge clk) begin
      if (gen_start === 1'b1)  gs_cnt++;
      if (sweep_done === 1'b1) sd_cnt++;
   end

   function automatic bit model_keep(input logic [7:0] b);
`ifdef RTC_BCD_CHECK_EN
      return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
`else
      return 1'b1;
`endif
   endfunction

   // One generator frame: waits for gen_start, then plays address, data and release phases.
   task automatic gen_frame(input bit exp_read, input logic [7:0] exp_addr,
                            input logic [7:0] payload, input bit abort_in_data);
      int w;
      w = 0;
      while (gen_start !== 1'b1 && w < 60) begin
         @(negedge clk);
         w++;
      end
      n_cmp++;
      if (gen_start !== 1'b1) begin
         n_bad++;
         $display("FAIL gen_start_wait: gen_start=%b after %0d cycles, required 1", gen_start, w);
         return;
      end
      n_cmp++;
      if (indicador_maquina !== exp_read) begin
         n_bad++;
         $display("FAIL indicador: got %b required %b", indicador_maquina, exp_read);
      end
      cs_n = 1'b0;
      ad_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if (ad_oe !== 1'b1 || ad_out !== exp_addr) begin
            n_bad++;
            $display("FAIL addr_phase: ad_oe=%b ad_out=%h required oe=1 addr=%h", ad_oe, ad_out, exp_addr);
         end
      end
      @(negedge clk);
      ad_n = 1'b1;
      #1;
      n_cmp++;
      if (ad_oe !== 1'b0) begin
         n_bad++;
         $display("FAIL addr_release: ad_oe=%b required 0", ad_oe);
      end
      @(negedge clk);
      if (exp_read) begin
         rd_n  = 1'b0;
         ad_in = payload;
      end else begin
         wr_n = 1'b0;
      end
      if (abort_in_data) return;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if (exp_read ? (ad_oe !== 1'b0) : (ad_oe !== 1'b1 || ad_out !== payload)) begin
            n_bad++;
            $display("FAIL data_phase: ad_oe=%b ad_out=%h required oe=%b data=%h",
                     ad_oe, ad_out, !exp_read, payload);
         end
         @(negedge clk);
      end
      rd_n = 1'b1;
      wr_n = 1'b1;
      @(negedge clk);
      cs_n  = 1'b1;
      ad_in = 8'($urandom);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (dut_t[i] !== exp_t[i]) begin
            n_bad++;
            $display("FAIL %s_reg%0d: got %h required %h", tag, i, dut_t[i], exp_t[i]);
         end
      end
   endtask

   task automatic run_sweep(input logic [7:0] data [6], input string tag);
      int gs0, sd0;
      #2;
      gs0 = gs_cnt;
      sd0 = sd_cnt;
      @(negedge clk); sweep_req = 1'b1;
      @(negedge clk); sweep_req = 1'b0;
      n_cmp++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_accept: timeout_err=%b busy=%b required 0/1", tag, timeout_err, busy);
      end
      exp_bcd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         gen_frame(1'b1, 8'h21 + 8'(i), data[i], 1'b0);
         if (model_keep(data[i])) exp_t[i] = data[i];
         else                     exp_bcd  = 1'b1;
      end
      repeat (3) @(negedge clk);
      #2;
      n_cmp++;
      if (gs_cnt - gs0 != 6 || sd_cnt - sd0 != 1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_counts: starts=%0d done=%0d busy=%b required 6/1/0",
                  tag, gs_cnt - gs0, sd_cnt - sd0, busy);
      end
`ifdef RTC_BCD_CHECK_EN
      n_cmp++;
      if (bcd_err !== exp_bcd) begin
         n_bad++;
         $display("FAIL %s_bcd_err: got %b required %b", tag, bcd_err, exp_bcd);
      end
`endif
      check_regs(tag);
      $display("sweep %s: data %h %h %h %h %h %h -> regs %h %h %h %h %h %h", tag,
               data[0], data[1], data[2], data[3], data[4], data[5],
               sec, min, hour, day, month, year);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || gen_start !== 1'b0 || indicador_maquina !== 1'b1 || ad_oe !== 1'b0 ||
          ad_out !== 8'h00 || sweep_done !== 1'b0 || timeout_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b gs=%b ind=%b oe=%b out=%h sd=%b to=%b required 0 0 1 0 00 0 0",
                  busy, gen_start, indicador_maquina, ad_oe, ad_out, sweep_done, timeout_err);
      end
      for (int i = 0; i < 6; i++) exp_t[i] = 8'h00;
      check_regs("reset");
      reset = 1'b0;
      $display("reset: released");
   endtask

   task automatic test_sweep();
      logic [7:0] d [6];
      d = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h03, 8'h24};
      run_sweep(d, "sweep_directed");
   endtask

   task automatic test_write(input logic [7:0] a, input logic [7:0] v, input bit collide, input string tag);
      int gs0, sd0;
      #2;
      gs0 = gs_cnt;
      sd0 = sd_cnt;
      @(negedge clk);
      wr_req = 1'b1; wr_addr = a; wr_data = v; sweep_req = collide;
      @(negedge clk);
      wr_req = 1'b0; sweep_req = 1'b0;
      wr_addr = 8'($urandom); wr_data = 8'($urandom);
      gen_frame(1'b0, a, v, 1'b0);
      if (collide) sweep_req = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL %s_busy_before_cs: got %b required 1", tag, busy);
      end
      @(negedge clk);
      sweep_req = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_busy_after_cs: got %b required 0", tag, busy);
      end
      repeat (20) @(negedge clk);
      #2;
      n_cmp++;
      if (gs_cnt - gs0 != 1 || sd_cnt - sd0 != 0) begin
         n_bad++;
         $display("FAIL %s_counts: starts=%0d done=%0d required 1/0", tag, gs_cnt - gs0, sd_cnt - sd0);
      end
      check_regs(tag);
      $display("write %s: addr %h data %h collide %0d", tag, a, v, collide);
   endtask

   task automatic test_random();
      logic [7:0] d [6];
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
         run_sweep(d, $sformatf("sweep_rand%0d", r));
         test_write(8'($urandom), 8'($urandom), 1'b0, $sformatf("write_rand%0d", r));
      end
   endtask

   task automatic test_timeout();
      int c, sd0;
      logic [7:0] d [6];
      #2;
      sd0 = sd_cnt;
      @(negedge clk); sweep_req = 1'b1;
      @(negedge clk); sweep_req = 1'b0;
      c = 0;
      while (busy === 1'b1 && c < 400) begin
         @(negedge clk);
         c++;
      end
      #1;
      n_cmp++;
      if (c < 198 || c > 204 || timeout_err !== 1'b1 || ad_oe !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout: cycles=%0d err=%b oe=%b busy=%b required ~200/1/0/0",
                  c, timeout_err, ad_oe, busy);
      end
      #1;
      n_cmp++;
      if (sd_cnt != sd0) begin
         n_bad++;
         $display("FAIL timeout_sweep_done: pulses=%0d required 0", sd_cnt - sd0);
      end
      check_regs("timeout");
      $display("timeout: busy fell after %0d cycles, timeout_err=%b", c, timeout_err);
      for (int i = 0; i < 6; i++) d[i] = 8'($urandom);
      run_sweep(d, "after_timeout");
   endtask

   task automatic test_reset_mid();
      logic [7:0] d [6];
      d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h06};
      @(negedge clk); sweep_req = 1'b1;
      @(negedge clk); sweep_req = 1'b0;
      gen_frame(1'b1, 8'h21, d[0], 1'b0);
      gen_frame(1'b1, 8'h22, d[1], 1'b0);
      gen_frame(1'b1, 8'h23, d[2], 1'b1);
      #3;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || gen_start !== 1'b0 || indicador_maquina !== 1'b1 || ad_oe !== 1'b0 ||
          ad_out !== 8'h00 || sweep_done !== 1'b0 || timeout_err !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_outputs: busy=%b gs=%b ind=%b oe=%b out=%h sd=%b to=%b",
                  busy, gen_start, indicador_maquina, ad_oe, ad_out, sweep_done, timeout_err);
      end
      for (int i = 0; i < 6; i++) exp_t[i] = 8'h00;
      check_regs("midreset");
      cs_n = 1'b1; ad_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      $display("midreset: asserted in DATA of read 3, released");
   endtask

`ifdef RTC_BCD_CHECK_EN
   task automatic test_bcd();
      logic [7:0] d [6];
      d = '{8'h45, 8'h5A, 8'h12, 8'h07, 8'h03, 8'h24};
      run_sweep(d, "bcd_bad_min");
   endtask
`endif

   initial begin
      test_reset();
      test_sweep();
      test_write(8'h23, 8'h09, 1'b0, "write_directed");
      test_write(8'h25, 8'h17, 1'b1, "collision");
      test_random();
      test_timeout();
      test_reset_mid();
`ifdef RTC_BCD_CHECK_EN
      test_bcd();
`endif
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
